// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX scheduler.
package uart_pkg;

    localparam int UART_WORD_W    = 16;
    localparam int UART_BYTE_W    = 8;
    localparam int UART_GAP_W_DEF = 8;
    localparam int UART_CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        LOAD    = 3'd2,
        SEND_LO = 3'd3,
        SEND_HI = 3'd4,
        GAP     = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_tx_sched_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the async level through two flops before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_sched.sv
// UART TX scheduler: pops one 16-bit word from the TX FIFO, hands its low then
// high byte to the serializer over valid/ready, then idles for gap_cfg cycles.
// Optional CTS flow control is built when UART_TX_CTS_FLOW_EN is defined.
//
// state   | meaning
// IDLE    | waiting for enable and a non-empty FIFO, issues the pop
// POP     | FIFO read latency cycle
// LOAD    | capture FIFO word, present low byte
// SEND_LO | low byte presented, waiting for handshake (or CTS between bytes)
// SEND_HI | high byte presented, waiting for handshake
// GAP     | inter-word idle countdown
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int GAP_W = UART_GAP_W_DEF,
    parameter int CNT_W = UART_CNT_W_DEF
) (
`ifdef UART_TX_CTS_FLOW_EN
    input  logic                   cts_n,
`endif
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [GAP_W-1:0]       gap_cfg,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [UART_WORD_W-1:0] fifo_rd_data,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       words_sent
);

    tx_state_e              state_q;
    logic                   fifo_rd_en_q;
    logic                   tx_valid_q;
    logic                   hi_sel_q;
    logic [UART_WORD_W-1:0] hold_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       words_sent_q;
    logic                   cts_ok;

`ifdef UART_TX_CTS_FLOW_EN
    logic cts_n_sync;

    // Idle-high reset value keeps the scheduler quiet until CTS is really seen.
    sync_2ff #(.RST_VAL(1'b1)) u_cts_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cts_n),
        .q_o   (cts_n_sync)
    );

    assign cts_ok = ~cts_n_sync;
`else
    assign cts_ok = 1'b1;
`endif

    // Word sequencing FSM; all handshake outputs and status are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fifo_rd_en_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            hi_sel_q     <= 1'b0;
            hold_q       <= '0;
            gap_q        <= '0;
            busy_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            fifo_rd_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (enable && !fifo_empty && cts_ok) begin
                        fifo_rd_en_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= POP;
                    end
                end
                POP: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    hold_q     <= fifo_rd_data;
                    hi_sel_q   <= 1'b0;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND_LO;
                end
                SEND_LO: begin
                    // !tx_valid_q here means the low byte is gone and only CTS blocks us
                    if (!tx_valid_q || tx_ready) begin
                        if (cts_ok) begin
                            hi_sel_q   <= 1'b1;
                            tx_valid_q <= 1'b1;
                            state_q    <= SEND_HI;
                        end else begin
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                SEND_HI: begin
                    if (tx_ready) begin
                        tx_valid_q   <= 1'b0;
                        words_sent_q <= words_sent_q + CNT_W'(1);
                        if (gap_cfg == '0) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            gap_q   <= gap_cfg;
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    gap_q <= gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = hi_sel_q ? hold_q[15:8] : hold_q[7:0];
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  gap_cfg = 8'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = 16'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [15:0] words_sent;
`ifdef UART_TX_CTS_FLOW_EN
    logic        cts_n = 1'b0;
`endif

    uart_tx_sched dut (
`ifdef UART_TX_CTS_FLOW_EN
        .cts_n        (cts_n),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .gap_cfg      (gap_cfg),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int          rd_pulses = 0;
    int          cyc = 0;
    int          rd_cyc_prev = 0;
    int          rd_cyc_last = 0;
    logic        prev_stall = 1'b0;
    logic        prev_rd = 1'b0;
    logic [7:0]  prev_data = 8'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    task automatic wait_done(input string name, input int remain, input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(exp_q.size() == remain && !busy) && n < budget);
        checks++;
        if (!(exp_q.size() == remain && !busy)) begin
            errors++;
            $display("FAIL %s: timeout, %0d bytes pending, busy=%0b, expected %0d pending and idle",
                     name, exp_q.size(), busy, remain);
        end
    endtask

    task automatic wait_rd(input string name, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_rd_en && n < budget);
        checks++;
        if (!fifo_rd_en) begin
            errors++;
            $display("FAIL %s: no fifo_rd_en within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < budget);
        checks++;
        if (!tx_valid) begin
            errors++;
            $display("FAIL %s: no tx_valid within %0d cycles", name, budget);
        end
    endtask

    // Scoreboard monitor and FIFO model: compare handshaken bytes, police stalls and pops.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
            end
            if (fifo_rd_en) begin
                rd_pulses++;
                rd_cyc_prev = rd_cyc_last;
                rd_cyc_last = cyc;
                check("pop_nonempty", fifo_empty, 0);
                check("pop_single_cycle", prev_rd, 0);
                if (fifo_q.size() != 0) begin
                    fifo_rd_data = fifo_q.pop_front();
                    fifo_empty = (fifo_q.size() == 0);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_rd    = fifo_rd_en;
        end else begin
            prev_stall = 1'b0;
            prev_rd    = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int lat;
        int blo;
        int rd0;
        logic v3;

        // Reset values
        #12;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_words", words_sent, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Single word, ready high, no gap
        @(posedge clk); #1;
        enable = 1'b1; tx_ready = 1'b1; gap_cfg = 8'd0;
        push_word(16'hA55A);
        wait_rd("t1_pop", 20, n);
        lat = -1; blo = -1; v3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (tx_valid && lat < 0) lat = k;
            if (k == 3) v3 = tx_valid;
            if (!busy && blo < 0) blo = k;
        end
        // rd_en is seen in POP, so first byte is 2 samples later (3 counting the IDLE cycle)
        check("t1_latency", lat, 2);
        check("t1_hi_back_to_back", v3, 1);
        check("t1_busy_len", blo, 4);
        wait_done("t1_done", 0, 50);
        check("t1_words", words_sent, 1);

        // Two words with gap 3: pop-to-pop is 5 cycles word period + 3 gap
        @(posedge clk); #1;
        gap_cfg = 8'd3;
        rd0 = rd_pulses;
        push_word(16'h1234);
        push_word(16'hBEEF);
        wait_done("t2_done", 0, 100);
        check("t2_pops", rd_pulses - rd0, 2);
        check("t2_pop_interval", rd_cyc_last - rd_cyc_prev, 8);
        check("t2_words", words_sent, 3);

        // Serializer stalls for 10 cycles on the low byte
        @(posedge clk); #1;
        gap_cfg = 8'd0; tx_ready = 1'b0;
        push_word(16'hC3D4);
        wait_valid("t3_valid", 20);
        rd0 = rd_pulses;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_hold_valid", tx_valid, 1);
            check("t3_hold_data", tx_data, 8'hD4);
        end
        check("t3_no_extra_pop", rd_pulses - rd0, 0);
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_done("t3_done", 0, 50);
        check("t3_words", words_sent, 4);

        // enable dropped right after the pop: word finishes, nothing else popped
        @(posedge clk); #1;
        rd0 = rd_pulses;
        push_word(16'h00FF);
        push_word(16'h7777);
        wait_rd("t4_pop", 20, n);
        @(posedge clk); #1 enable = 1'b0;
        wait_done("t4_first", 2, 50);
        repeat (20) @(negedge clk);
        #1;
        check("t4_pops", rd_pulses - rd0, 1);
        check("t4_fifo_left", fifo_q.size(), 1);
        check("t4_words", words_sent, 5);
        @(posedge clk); #1 enable = 1'b1;
        wait_done("t4_drain", 0, 50);
        check("t4_words_drain", words_sent, 6);

        // Counter wrap from 0xFFFF
        @(negedge clk);
        force dut.words_sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.words_sent_q;
        #1;
        check("t5_preload", words_sent, 16'hFFFF);
        @(posedge clk); #1;
        push_word(16'h0102);
        wait_done("t5_done", 0, 50);
        check("t5_wrap", words_sent, 16'h0000);

        // Reset while the high byte is waiting for ready
        @(posedge clk); #1 tx_ready = 1'b0;
        push_word(16'h1357);
        wait_valid("t6_valid", 20);
        @(posedge clk); #1 tx_ready = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;
        @(negedge clk);
        check("t6_in_hi_valid", tx_valid, 1);
        check("t6_in_hi_data", tx_data, 8'h13);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", tx_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b1;
        push_word(16'h8642);
        wait_done("t6_recover", 0, 50);
        check("t6_words", words_sent, 1);

`ifdef UART_TX_CTS_FLOW_EN
        // CTS deasserted blocks the pop; release pops within 3 cycles
        @(posedge clk); #1 cts_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd0 = rd_pulses;
        push_word(16'h5AA5);
        repeat (20) @(negedge clk);
        check("cts_blocked", rd_pulses - rd0, 0);
        @(posedge clk); #1 cts_n = 1'b0;
        wait_rd("cts_release", 3, n);
        wait_done("cts_done", 0, 50);
        check("cts_words", words_sent, 2);
`endif

        check("final_fifo_empty", fifo_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
